// File: rtl/mod_exposure_sequencer.sv
// Exposure sequencer: walks a frame through drain / expose / readout for each
// subframe, stepping the modulation phase between subframes.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for START, drain asserted, configuration not latched
// ST_DRAIN   | DRAIN_B held low for DRAIN_CYCLES cycles before exposure
// ST_EXPOSE  | DRAIN_B released, counting CLK_MODL rising edges
// ST_READOUT | DRAIN_B low, READOUT_REQ high until READOUT_ACK
module mod_exposure_sequencer #(
  parameter int DRAIN_CYCLES = 256,
  parameter int PCNT_W       = 16
) (
  input  logic              CLK_IN,
  input  logic              RST_B,
  input  logic              START,
  input  logic              ABORT,
  input  logic [3:0]        NUM_SUBFRAMES,
  input  logic [PCNT_W-1:0] PERIODS_PER_SUB,
  input  logic [4:0]        PHASE_BASE,
  input  logic [4:0]        PHASE_STEP,
  input  logic [3:0]        DUTY_CFG,
  input  logic              CLK_MODL,
  input  logic              READOUT_ACK,
  output logic              DRAIN_B,
  output logic [4:0]        PHASE_SEL,
  output logic [3:0]        DUTY_SEL,
  output logic [3:0]        SUBFRAME_IDX,
  output logic              READOUT_REQ,
  output logic              BUSY,
  output logic              DONE
);

  // Drain timer is a down-counter loaded with DRAIN_CYCLES-1; terminal count 0.
  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE   = PCNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_EXPOSE,
    ST_READOUT
  } state_t;

  state_t              r_state;
  logic [DCNT_W-1:0]   r_dcnt;
  logic [PCNT_W-1:0]   r_pcnt;
  logic [PCNT_W-1:0]   r_pcnt_last;
  logic [3:0]          r_last_idx;
  logic [4:0]          r_phase_step;
  logic                r_modl_prev;
  logic                r_drain_b;
  logic [4:0]          r_phase_sel;
  logic [3:0]          r_duty_sel;
  logic [3:0]          r_sub_idx;
  logic                r_req;
  logic                r_busy;
  logic                r_done;

  logic [3:0]          w_last_idx;
  logic [PCNT_W-1:0]   w_pcnt_last;
  logic                w_modl_edge;

  // Zero subframes / zero periods behave as one; store the terminal values.
  assign w_last_idx  = (NUM_SUBFRAMES == 4'd0) ? 4'd0 : (NUM_SUBFRAMES - 4'd1);
  assign w_pcnt_last = (PERIODS_PER_SUB == '0) ? '0 : (PERIODS_PER_SUB - PCNT_ONE);
  assign w_modl_edge = CLK_MODL & ~r_modl_prev;

  // Sequencer FSM with all outputs registered; ABORT overrides everything else.
  always_ff @(posedge CLK_IN or negedge RST_B) begin
    if (!RST_B) begin
      r_state      <= ST_IDLE;
      r_dcnt       <= '0;
      r_pcnt       <= '0;
      r_pcnt_last  <= '0;
      r_last_idx   <= 4'd0;
      r_phase_step <= 5'd0;
      r_modl_prev  <= 1'b0;
      r_drain_b    <= 1'b0;
      r_phase_sel  <= 5'd0;
      r_duty_sel   <= 4'd0;
      r_sub_idx    <= 4'd0;
      r_req        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ABORT && (r_state != ST_IDLE)) begin
        // Phase and duty deliberately left as they were.
        r_state   <= ST_IDLE;
        r_drain_b <= 1'b0;
        r_req     <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_drain_b <= 1'b0;
            if (START && !ABORT) begin
              r_state      <= ST_DRAIN;
              r_busy       <= 1'b1;
              r_last_idx   <= w_last_idx;
              r_pcnt_last  <= w_pcnt_last;
              r_phase_step <= PHASE_STEP;
              r_phase_sel  <= PHASE_BASE;
              r_duty_sel   <= DUTY_CFG;
              r_sub_idx    <= 4'd0;
              r_dcnt       <= DRAIN_LOAD;
              r_pcnt       <= '0;
            end
          end
          ST_DRAIN: begin
            if (r_dcnt == '0) begin
              r_state     <= ST_EXPOSE;
              r_drain_b   <= 1'b1;
              // Cleared so a CLK_MODL already high counts as the first edge.
              r_modl_prev <= 1'b0;
            end else begin
              r_dcnt <= r_dcnt - 1'b1;
            end
          end
          ST_EXPOSE: begin
            r_modl_prev <= CLK_MODL;
            if (w_modl_edge) begin
              if (r_pcnt == r_pcnt_last) begin
                r_state   <= ST_READOUT;
                r_drain_b <= 1'b0;
                r_req     <= 1'b1;
              end else begin
                r_pcnt <= r_pcnt + PCNT_ONE;
              end
            end
          end
          ST_READOUT: begin
            if (READOUT_ACK) begin
              r_req <= 1'b0;
              if (r_sub_idx == r_last_idx) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state     <= ST_DRAIN;
                r_sub_idx   <= r_sub_idx + 4'd1;
                r_phase_sel <= r_phase_sel + r_phase_step;
                r_dcnt      <= DRAIN_LOAD;
                r_pcnt      <= '0;
              end
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_drain_b <= 1'b0;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DRAIN_B      = r_drain_b;
  assign PHASE_SEL    = r_phase_sel;
  assign DUTY_SEL     = r_duty_sel;
  assign SUBFRAME_IDX = r_sub_idx;
  assign READOUT_REQ  = r_req;
  assign BUSY         = r_busy;
  assign DONE         = r_done;

endmodule

// File: tb/tb_mod_exposure_sequencer.sv
// Directed bench for mod_exposure_sequencer with a small drain length.
module tb_mod_exposure_sequencer;

  localparam int DC = 4;
  localparam int PW = 16;

  logic          CLK_IN;
  logic          RST_B;
  logic          START;
  logic          ABORT;
  logic [3:0]    NUM_SUBFRAMES;
  logic [PW-1:0] PERIODS_PER_SUB;
  logic [4:0]    PHASE_BASE;
  logic [4:0]    PHASE_STEP;
  logic [3:0]    DUTY_CFG;
  logic          CLK_MODL;
  logic          READOUT_ACK;
  logic          DRAIN_B;
  logic [4:0]    PHASE_SEL;
  logic [3:0]    DUTY_SEL;
  logic [3:0]    SUBFRAME_IDX;
  logic          READOUT_REQ;
  logic          BUSY;
  logic          DONE;

  int n_tests = 0;
  int n_fail  = 0;

  mod_exposure_sequencer #(.DRAIN_CYCLES(DC), .PCNT_W(PW)) dut (
    .CLK_IN          (CLK_IN),
    .RST_B           (RST_B),
    .START           (START),
    .ABORT           (ABORT),
    .NUM_SUBFRAMES   (NUM_SUBFRAMES),
    .PERIODS_PER_SUB (PERIODS_PER_SUB),
    .PHASE_BASE      (PHASE_BASE),
    .PHASE_STEP      (PHASE_STEP),
    .DUTY_CFG        (DUTY_CFG),
    .CLK_MODL        (CLK_MODL),
    .READOUT_ACK     (READOUT_ACK),
    .DRAIN_B         (DRAIN_B),
    .PHASE_SEL       (PHASE_SEL),
    .DUTY_SEL        (DUTY_SEL),
    .SUBFRAME_IDX    (SUBFRAME_IDX),
    .READOUT_REQ     (READOUT_REQ),
    .BUSY            (BUSY),
    .DONE            (DONE)
  );

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Phase/duty may only move while the clock generator is drained.
  logic [4:0] mon_phase = 5'd0;
  logic [3:0] mon_duty  = 4'd0;
  always @(negedge CLK_IN) begin
    if ((PHASE_SEL !== mon_phase) || (DUTY_SEL !== mon_duty))
      check_eq("cfg_change_needs_drain", 32'(DRAIN_B), 32'd0);
    mon_phase = PHASE_SEL;
    mon_duty  = DUTY_SEL;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_frame(input logic [3:0] num, input logic [PW-1:0] per,
                             input logic [4:0] base, input logic [4:0] step,
                             input logic [3:0] duty);
    NUM_SUBFRAMES   = num;
    PERIODS_PER_SUB = per;
    PHASE_BASE      = base;
    PHASE_STEP      = step;
    DUTY_CFG        = duty;
    START           = 1'b1;
    @(negedge CLK_IN);
    START           = 1'b0;
    // Latched configuration must ignore later input changes.
    NUM_SUBFRAMES   = 4'($urandom);
    PERIODS_PER_SUB = PW'($urandom);
    PHASE_BASE      = 5'($urandom);
    PHASE_STEP      = 5'($urandom);
    DUTY_CFG        = 4'($urandom);
  endtask

  task automatic count_drain();
    int cnt;
    cnt = 0;
    while ((DRAIN_B == 1'b0) && (cnt < 100)) begin
      cnt++;
      @(negedge CLK_IN);
    end
    check_eq("drain_len", cnt, DC);
  endtask

  // Entered at the first DRAIN cycle of a subframe; leaves just after the ACK.
  task automatic do_sub(input logic [4:0] ph, input logic [3:0] duty, input logic [3:0] idx,
                        input int edges, input bit last, input bit ack_held);
    check_eq("sub_phase", 32'(PHASE_SEL), 32'(ph));
    check_eq("sub_duty", 32'(DUTY_SEL), 32'(duty));
    check_eq("sub_idx", 32'(SUBFRAME_IDX), 32'(idx));
    check_eq("sub_busy", 32'(BUSY), 32'd1);
    count_drain();
    for (int i = 0; i < edges; i++) begin
      CLK_MODL = 1'b1;
      @(negedge CLK_IN);
      if (i < edges - 1) begin
        check_eq("req_early", 32'(READOUT_REQ), 32'd0);
        check_eq("drain_b_expose", 32'(DRAIN_B), 32'd1);
        CLK_MODL = 1'b0;
        @(negedge CLK_IN);
      end else begin
        check_eq("req_on_nth_edge", 32'(READOUT_REQ), 32'd1);
        check_eq("drain_b_readout", 32'(DRAIN_B), 32'd0);
      end
    end
    if (!ack_held) begin
      START = 1'b1;
      repeat (2) @(negedge CLK_IN);
      START = 1'b0;
      check_eq("req_hold", 32'(READOUT_REQ), 32'd1);
      READOUT_ACK = 1'b1;
    end
    @(negedge CLK_IN);
    if (!ack_held) READOUT_ACK = 1'b0;
    check_eq("req_drop", 32'(READOUT_REQ), 32'd0);
    if (last) begin
      check_eq("done_pulse", 32'(DONE), 32'd1);
      check_eq("busy_end", 32'(BUSY), 32'd0);
      @(negedge CLK_IN);
      check_eq("done_once", 32'(DONE), 32'd0);
    end else begin
      check_eq("done_mid", 32'(DONE), 32'd0);
      check_eq("busy_mid", 32'(BUSY), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_drain_b"}, 32'(DRAIN_B), 32'd0);
    check_eq({tag, "_phase"}, 32'(PHASE_SEL), 32'd0);
    check_eq({tag, "_duty"}, 32'(DUTY_SEL), 32'd0);
    check_eq({tag, "_idx"}, 32'(SUBFRAME_IDX), 32'd0);
    check_eq({tag, "_req"}, 32'(READOUT_REQ), 32'd0);
    check_eq({tag, "_busy"}, 32'(BUSY), 32'd0);
    check_eq({tag, "_done"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    RST_B = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    NUM_SUBFRAMES = 4'd0;
    PERIODS_PER_SUB = '0;
    PHASE_BASE = 5'd0;
    PHASE_STEP = 5'd0;
    DUTY_CFG = 4'd0;
    CLK_MODL = 1'b0;
    READOUT_ACK = 1'b0;
    #1 RST_B = 1'b0;
    repeat (3) @(negedge CLK_IN);
    check_reset_outputs("reset");
    RST_B = 1'b1;
    @(negedge CLK_IN);
    check_eq("idle_busy", 32'(BUSY), 32'd0);

    // Basic two-subframe frame.
    start_frame(4'd2, 16'd3, 5'd4, 5'd8, 4'd5);
    do_sub(5'd4, 4'd5, 4'd0, 3, 1'b0, 1'b0);
    do_sub(5'd12, 4'd5, 4'd1, 3, 1'b1, 1'b0);

    // Phase wraps modulo 32; CLK_MODL stays high across subframes.
    start_frame(4'd3, 16'd1, 5'd30, 5'd5, 4'd9);
    do_sub(5'd30, 4'd9, 4'd0, 1, 1'b0, 1'b0);
    do_sub(5'd3, 4'd9, 4'd1, 1, 1'b0, 1'b0);
    do_sub(5'd8, 4'd9, 4'd2, 1, 1'b1, 1'b0);

    // ABORT in IDLE beats START.
    CLK_MODL = 1'b0;
    ABORT = 1'b1;
    START = 1'b1;
    @(negedge CLK_IN);
    ABORT = 1'b0;
    START = 1'b0;
    check_eq("abort_idle_busy", 32'(BUSY), 32'd0);

    // ABORT in EXPOSE after one edge, with START and ACK in the same cycle.
    start_frame(4'd3, 16'd4, 5'd7, 5'd3, 4'd2);
    count_drain();
    CLK_MODL = 1'b1;
    @(negedge CLK_IN);
    CLK_MODL = 1'b0;
    check_eq("abort_pre_req", 32'(READOUT_REQ), 32'd0);
    ABORT = 1'b1;
    START = 1'b1;
    READOUT_ACK = 1'b1;
    @(negedge CLK_IN);
    ABORT = 1'b0;
    START = 1'b0;
    READOUT_ACK = 1'b0;
    check_eq("abort_busy", 32'(BUSY), 32'd0);
    check_eq("abort_drain_b", 32'(DRAIN_B), 32'd0);
    check_eq("abort_req", 32'(READOUT_REQ), 32'd0);
    check_eq("abort_done", 32'(DONE), 32'd0);
    check_eq("abort_phase_kept", 32'(PHASE_SEL), 32'd7);
    check_eq("abort_duty_kept", 32'(DUTY_SEL), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_IN);
      check_eq("abort_no_done", 32'(DONE), 32'd0);
    end
    start_frame(4'd1, 16'd2, 5'd9, 5'd1, 4'd6);
    do_sub(5'd9, 4'd6, 4'd0, 2, 1'b1, 1'b0);

    // Zero subframes and zero periods behave as one each.
    start_frame(4'd0, 16'd0, 5'd17, 5'd1, 4'd3);
    do_sub(5'd17, 4'd3, 4'd0, 1, 1'b1, 1'b0);

    // ACK held high throughout: one-cycle REQ, spurious ACK elsewhere ignored.
    CLK_MODL = 1'b0;
    READOUT_ACK = 1'b1;
    start_frame(4'd2, 16'd2, 5'd1, 5'd31, 4'd4);
    do_sub(5'd1, 4'd4, 4'd0, 2, 1'b0, 1'b1);
    do_sub(5'd0, 4'd4, 4'd1, 2, 1'b1, 1'b1);
    READOUT_ACK = 1'b0;

    // Asynchronous reset while REQ is high.
    CLK_MODL = 1'b0;
    start_frame(4'd2, 16'd1, 5'd10, 5'd1, 4'd7);
    count_drain();
    CLK_MODL = 1'b1;
    @(negedge CLK_IN);
    check_eq("rst_pre_req", 32'(READOUT_REQ), 32'd1);
    #2 RST_B = 1'b0;
    #1 check_reset_outputs("async_rst");
    START = 1'b1;
    repeat (2) @(negedge CLK_IN);
    check_eq("rst_start_ignored", 32'(BUSY), 32'd0);
    START = 1'b0;
    RST_B = 1'b1;
    repeat (2) @(negedge CLK_IN);
    check_reset_outputs("post_rst");
    start_frame(4'd1, 16'd1, 5'd10, 5'd1, 4'd7);
    do_sub(5'd10, 4'd7, 4'd0, 1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
